// File: rtl/logic_fold_unit.sv
// Registered bitwise logic stage with valid/ready handshake.
// Folds multi-beat bursts into one result and counts the beats.
module logic_fold_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       op,
  input  logic             acc_en,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [CNT_W-1:0] out_cnt
);

  typedef enum logic {IDLE, ACC} state_t;

  state_t state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] out_y_q, out_y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [2:0]       op_l_q, op_l_d;
  logic             out_valid_q, out_valid_d;
  logic             fire, load;
  logic [1:0]       sel;
  logic [WIDTH-1:0] r, folded;

  function automatic logic [WIDTH-1:0] base(
    input logic [1:0]       s,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] x;
    unique case (s)
      2'd0: x = a & b;
      2'd1: x = a | b;
      2'd2: x = a ^ b;
      2'd3: x = a;
    endcase
    return x;
  endfunction

  assign in_ready  = ~out_valid_q | out_ready;
  assign fire      = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_cnt   = out_cnt_q;

  // Counter sticks at all-ones; the fold itself keeps going.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  assign sel = (state_q == ACC) ? op_l_q[1:0] : op[1:0];
  assign r   = base(sel, in_a, in_b);

  always_comb begin
    folded = r;
    unique case (op_l_q[1:0])
      2'd0: folded = acc_q & r;
      2'd1: folded = acc_q | r;
      2'd2: folded = acc_q ^ r;
      2'd3: folded = r;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    op_l_d    = op_l_q;
    out_y_d   = out_y_q;
    out_cnt_d = out_cnt_q;
    load      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fire) begin
          if (acc_en && !in_last) begin
            acc_d   = r;
            cnt_d   = CNT_W'(1);
            op_l_d  = op;
            state_d = ACC;
          end else begin
            load      = 1'b1;
            out_y_d   = op[2] ? ~r : r;
            out_cnt_d = CNT_W'(1);
          end
        end
      end
      ACC: begin
        if (fire) begin
          acc_d = folded;
          cnt_d = cnt_inc;
          if (in_last) begin
            load      = 1'b1;
            out_y_d   = op_l_q[2] ? ~folded : folded;
            out_cnt_d = cnt_inc;
            state_d   = IDLE;
          end
        end
      end
    endcase
    out_valid_d = load | (out_valid_q & ~out_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      op_l_q      <= '0;
      out_y_q     <= '0;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      op_l_q      <= op_l_d;
      out_y_q     <= out_y_d;
      out_cnt_q   <= out_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_logic_fold_unit.sv
// Scoreboard bench for logic_fold_unit (WIDTH=8, CNT_W=2).
// Stimulus pushes expected results; a monitor pops on each handshake.
module tb_logic_fold_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic [2:0] op = '0;
  logic       acc_en = 1'b0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_y;
  logic [1:0] out_cnt;

  typedef struct {
    logic [7:0] y;
    logic [1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  logic_fold_unit #(.WIDTH(8), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .op(op),
    .acc_en(acc_en), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic expect_out(input logic [7:0] y, input logic [1:0] c);
    exp_t e;
    e.y = y;
    e.cnt = c;
    sb.push_back(e);
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] o, input logic ae,
                      input logic last);
    bit ok;
    in_a = a; in_b = b; op = o;
    acc_en = ae; in_last = last;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid === 1'b1 && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out y=%0h cnt=%0d required=none",
                 out_y, out_cnt);
      end else begin
        e = sb.pop_front();
        chk("out_y", 32'(out_y), 32'(e.y));
        chk("out_cnt", 32'(out_cnt), 32'(e.cnt));
      end
    end
  end

  logic [7:0] pb_exp [8];

  initial begin
    pb_exp = '{8'h30, 8'hFC, 8'hCC, 8'hF0,
               8'hCF, 8'h03, 8'h33, 8'h0F};

    in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF;
    repeat (2) begin
      @(negedge clk);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_y", 32'(out_y), 0);
      chk("rst_cnt", 32'(out_cnt), 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 0);
    idle(1);

    for (int i = 0; i < 8; i++) begin
      expect_out(pb_exp[i], 2'd1);
      send(8'hF0, 8'h3C, 3'(i), 1'b0, 1'b0);
    end
    idle(2);

    expect_out(8'h76, 2'd3);
    send(8'hFF, 8'hF7, 3'd0, 1'b1, 1'b0);
    idle(3);
    send(8'hFE, 8'hFF, 3'd0, 1'b1, 1'b0);
    send(8'h7F, 8'hFF, 3'd0, 1'b1, 1'b1);
    idle(2);

    expect_out(8'hF1, 2'd2);
    send(8'h0F, 8'h00, 3'd6, 1'b1, 1'b0);
    send(8'h01, 8'h00, 3'd0, 1'b0, 1'b1);
    idle(2);

    out_ready = 1'b0;
    expect_out(8'hAA, 2'd1);
    send(8'hAA, 8'hFF, 3'd0, 1'b0, 1'b0);
    expect_out(8'h3F, 2'd1);
    in_a = 8'h0F; in_b = 8'h30; op = 3'd1;
    acc_en = 1'b0; in_last = 1'b0;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_y_held", 32'(out_y), 32'h AA);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_reload_valid", 32'(out_valid), 1);
    chk("bp_reload_y", 32'(out_y), 32'h3F);
    idle(2);

    expect_out(8'h1F, 2'd3);
    send(8'h01, 8'h00, 3'd1, 1'b1, 1'b0);
    send(8'h02, 8'h00, 3'd1, 1'b1, 1'b0);
    send(8'h04, 8'h00, 3'd1, 1'b1, 1'b0);
    send(8'h08, 8'h00, 3'd1, 1'b1, 1'b0);
    send(8'h10, 8'h00, 3'd1, 1'b1, 1'b1);
    idle(2);

    send(8'h01, 8'h00, 3'd1, 1'b1, 1'b0);
    send(8'h02, 8'h00, 3'd1, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(out_valid), 0);
    idle(1);
    expect_out(8'h10, 2'd1);
    send(8'h10, 8'h00, 3'd1, 1'b1, 1'b1);

    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    idle(2);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
